// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared op and FSM encodings for the JK bank scheduler
package jk_pkg;
  // Ops are encoded {J,K} so a latched op drives the cells directly.
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high reset
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // Reset wins over any J/K drive in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        OP_HOLD:  q <= q;
        OP_CLEAR: q <= 1'b0;
        OP_SET:   q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_scheduler.sv
// rtl/jk_bank_scheduler.sv - round-robin arbiter applying masked JK commands to a flop bank
module jk_bank_scheduler
  import jk_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NREQ  = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        q,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id
);

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [IDW:0]     pick;
  logic [IDW-1:0]   pick_id;
  logic             grant;

  // Returns {found, index}; scanning downward lets the nearest requester at/after ptr win.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int n = NREQ - 1; n >= 0; n--) begin
      idx = IDW'((int'(ptr) + n) % NREQ);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick    = rr_pick(req_valid, rr_ptr);
  assign pick_id = pick[IDW-1:0];
  assign grant   = (state == ST_IDLE) && pick[IDW];

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[pick_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      id_r   <= '0;
      op_r   <= OP_HOLD;
      mask_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            id_r   <= pick_id;
            op_r   <= req_op[2*pick_id +: 2];
            mask_r <= req_mask[WIDTH*pick_id +: WIDTH];
            state  <= ST_APPLY;
          end
        end
        ST_APPLY: state <= ST_DONE;
        ST_DONE: begin
          rr_ptr <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state == ST_APPLY) begin
      j = mask_r & {WIDTH{op_r[1]}};
      k = mask_r & {WIDTH{op_r[0]}};
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[b]),
      .k     (k[b]),
      .q     (q[b])
    );
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign done_id = id_r;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb/tb_jk_bank_scheduler.sv - directed and randomized bench with a transaction-level reference model
module tb_jk_bank_scheduler;
  localparam int WIDTH = 2;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_mask;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;

  jk_bank_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester-side pending commands
  int pend [NREQ];
  int p_op [NREQ];
  int p_mask [NREQ];

  // Reference model: bank value, rr pointer, cycles elapsed since an acceptance
  int m_q, m_ptr, m_phase, m_id, m_op, m_mask;
  int last_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int jk_next(input int qv, input int op, input int mask);
    int r;
    r = qv;
    for (int b = 0; b < WIDTH; b++) begin
      if (mask[b]) begin
        if (op == 1) r[b] = 1'b0;
        else if (op == 2) r[b] = 1'b1;
        else if (op == 3) r[b] = ~r[b];
      end
    end
    return r & ((1 << WIDTH) - 1);
  endfunction

  function automatic int pick_ref(input int vb, input int ptr);
    for (int n = 0; n < NREQ; n++) begin
      if (vb[(ptr + n) % NREQ]) return (ptr + n) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      int opv, mkv;
      opv = p_op[i];
      mkv = p_mask[i];
      req_valid[i] = (pend[i] != 0);
      req_op[2*i +: 2] = opv[1:0];
      req_mask[WIDTH*i +: WIDTH] = mkv[WIDTH-1:0];
    end
  endtask

  task automatic model_reset();
    m_q = 0;
    m_ptr = 0;
    m_phase = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cycle();
    int vb, w, e_ready;
    drive();
    @(negedge clk);
    vb = 0;
    for (int i = 0; i < NREQ; i++) if (pend[i] != 0) vb |= (1 << i);
    last_grant = -1;
    if (m_phase == 0) begin
      w = pick_ref(vb, m_ptr);
      e_ready = (w >= 0) ? (1 << w) : 0;
      check("ready_idle", req_ready, e_ready);
      check("busy_idle", busy, 0);
      check("done_idle", done, 0);
      check("q_idle", q, m_q);
      if (w >= 0) begin
        last_grant = w;
        m_id = w;
        m_op = p_op[w];
        m_mask = p_mask[w];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      check("ready_apply", req_ready, 0);
      check("busy_apply", busy, 1);
      check("done_apply", done, 0);
      check("q_apply", q, m_q);
      m_q = jk_next(m_q, m_op, m_mask);
      m_phase = 2;
    end else begin
      check("ready_done", req_ready, 0);
      check("busy_done", busy, 1);
      check("done_pulse", done, 1);
      check("done_id", done_id, m_id);
      check("q_done", q, m_q);
      m_ptr = (m_id + 1) % NREQ;
      m_phase = 0;
    end
    @(posedge clk);
    #1;
    if (last_grant >= 0) pend[last_grant] = 0;
  endtask

  task automatic post(input int id, input int op, input int mask);
    pend[id] = 1;
    p_op[id] = op;
    p_mask[id] = mask;
  endtask

  task automatic run_idle();
    int busy_left;
    busy_left = 1;
    for (int g = 0; g < 40 && busy_left != 0; g++) begin
      cycle();
      busy_left = m_phase;
      for (int i = 0; i < NREQ; i++) busy_left |= pend[i];
    end
    check("drain_timeout", busy_left, 0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0;
      p_op[i] = 0;
      p_mask[i] = 0;
    end
    model_reset();
    do_reset(3);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 0);
    cycle();

    post(0, 2, 3);
    cycle();
    check("set_grant", last_grant, 0);
    cycle();
    cycle();
    check("set_q", q, 3);

    post(1, 3, 1);
    run_idle();
    check("toggle_q", q, 2);
    post(1, 1, 2);
    run_idle();
    check("clear_q", q, 0);

    do_reset(1);
    for (int n = 0; n < 4; n++) begin
      post(0, 3, 3);
      post(1, 3, 3);
      cycle();
      check("alt_grant", last_grant, n % 2);
      cycle();
      cycle();
      check("alt_q", q, (n % 2 == 0) ? 3 : 0);
    end
    pend[0] = 0;
    pend[1] = 0;

    do_reset(1);
    post(0, 2, 3);
    cycle();
    do_reset(1);
    check("abort_q", q, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    post(0, 2, 3);
    post(1, 2, 3);
    cycle();
    check("post_abort_grant", last_grant, 0);
    run_idle();
    check("post_abort_q", q, 3);

    post(1, 1, 2);
    run_idle();
    check("q01", q, 1);
    post(0, 0, 3);
    run_idle();
    check("hold_q", q, 1);
    post(1, 3, 0);
    run_idle();
    check("zero_mask_q", q, 1);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] == 0) begin
          if ($urandom_range(0, 2) == 0) post(i, $urandom_range(0, 3), $urandom_range(0, 3));
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
      end
      if ($urandom_range(0, 49) == 0) do_reset(1);
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_bank_scheduler.md
# jk_bank_scheduler

Round-robin command scheduler for a shared bank of JK flip-flops. Up to NREQ requesters each issue hold/clear/set/toggle commands with a per-bit mask. The block grants one command at a time, drives the J/K inputs of the selected bits for exactly one cycle, and reports completion. It sits in front of the JK state register used by the two-flop sequential circuits and replaces direct X/Y-style gating of J/K with an arbitrated, handshaked interface.

## Interface
- WIDTH, 2, number of JK flops in the bank
- NREQ, 2, number of requesters (2..8)
- clk  in  1  rising-edge clock (the only clock)
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_op  in  2*NREQ  requester i op in bits [2i+1:2i], encoded {J,K}: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE
- req_mask  in  WIDTH*NREQ  requester i mask in bits [WIDTH*i+WIDTH-1:WIDTH*i]; 1 = bit affected
- req_ready  out  NREQ  one-hot accept strobe; a command is taken when req_valid[i] & req_ready[i]
- q  out  WIDTH  current bank state
- busy  out  1  high in APPLY and DONE
- done  out  1  one-cycle completion pulse
- done_id  out  clog2(NREQ)  requester index of the completed command, valid when done=1

## Operation
- FSM states: IDLE, APPLY, DONE.
- IDLE: if any req_valid is set, select the winner by round-robin starting at pointer rr_ptr. Assert req_ready[winner] combinationally in the same cycle. Latch op, mask and id, then go to APPLY. With no valid request, stay in IDLE.
- APPLY: for each bit b with mask[b]=1, J=op[1] and K=op[0]; bits with mask[b]=0 get J=K=0. Go to DONE.
- DONE: done=1, done_id=latched id. Set rr_ptr = (id+1) mod NREQ. Go to IDLE.
- JK cell truth table: 00 hold, 01 Q←0, 10 Q←1, 11 Q←~Q.
- Requesters hold req_valid, req_op and req_mask stable until they see req_ready. req_ready is only ever asserted in IDLE.
- Only one req_ready bit is high in any cycle. It is never high for a requester whose req_valid is low.
- A HOLD command or an all-zero mask still completes the full handshake (done pulse); q is unchanged.
- Dropping req_valid before ready is legal; the request is simply not seen.

## Timing
- Reset values: state=IDLE, rr_ptr=0, q=0, busy=0, done=0, done_id=0, req_ready=0.
- Cycle t: IDLE with a valid request; req_ready pulses.
- Cycle t+1: APPLY, busy=1. q takes its new value at the t+1→t+2 edge.
- Cycle t+2: DONE, done=1, and q already shows the new value.
- Cycle t+3: IDLE; next acceptance is possible here.
- Throughput is one command per 3 cycles.
- Simultaneous requests: the lowest index at or after rr_ptr wins. The loser stays pending and wins at the next IDLE if it is still valid.
- Reset asserted in any state: at the next edge every register returns to reset value. The latched command is discarded with no done pulse, and q=0 even if APPLY was active.
- Reset has priority over the J/K drive in the JK cells.

## Structure
- Package jk_pkg holds:
  - op localparams OP_HOLD=2'b00, OP_CLEAR=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11
  - FSM state encoding ST_IDLE, ST_APPLY, ST_DONE
- Sub-module jk_cell: one JK flop with inputs clk, reset (sync, active-high), J, K and output Q, implementing the full truth table above.
- The scheduler instantiates WIDTH jk_cell instances via generate.
- The round-robin pick is a combinational function inside the scheduler.

## Test plan
- Reset held 3 cycles, then released → q=00, busy=0, done=0, req_ready=00.
- req0 SET mask 11 at cycle t → req_ready=01 at t, busy at t+1, done=1 with done_id=0 and q=11 at t+2.
- From q=11, req1 TOGGLE mask 01 → q=10 at done, done_id=1. Then req1 CLEAR mask 10 → q=00.
- After reset, req0 and req1 held valid continuously, both TOGGLE mask 11:
  - grants alternate 0,1,0,1, with acceptances 3 cycles apart
  - q alternates 11,00,11,00
- req0 SET mask 11 accepted, reset asserted during APPLY → no done pulse, q=00, rr_ptr=0. Next simultaneous request grants req0.
- req0 HOLD mask 11 from q=01 → done pulses and q remains 01. Also check that an all-zero mask with TOGGLE leaves q unchanged.
